// File: rtl/key_step_gen_pkg.sv
// step_pkg: key_step_gen FSM state encoding and shared widths
package step_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_DB_REL   = 2'd3;
  localparam int STEP_CNT_W = 16;
  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    DB_PRESS = ST_DB_PRESS,
    HELD     = ST_HELD,
    DB_REL   = ST_DB_REL
  } state_t;
endpackage

// File: rtl/key_step_gen_sync_2ff.sv
// sync_2ff: 2-flop synchronizer, ports CLK, RST (sync active-high, resets to 0), d (async in), q (synced out)
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge CLK)
    if (RST) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/key_step_gen.sv
// key_step_gen: debounced KEY_N -> one-cycle STEP_EN, KEY_LEVEL, 16-bit STEP_CNT; STEP_FREE_RUN_EN adds RUN_SW free-run divider
module key_step_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int RUN_DIV         = 25000000,
  parameter int DIV_W           = 25
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  KEY_N,
  input  logic                  RUN_SW,
  output logic                  STEP_EN,
  output logic                  KEY_LEVEL,
  output logic [STEP_CNT_W-1:0] STEP_CNT
);
  logic key_s, done, key_step, step;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  sync_2ff u_key (.CLK(CLK), .RST(RST), .d(~KEY_N), .q(key_s));
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    key_step = 1'b0;
    done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    case (state)
      IDLE: if (key_s) begin
        state_nx = DB_PRESS;
        cnt_nx = '0;
      end
      DB_PRESS: if (!key_s) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else if (done) begin
        state_nx = HELD;
        cnt_nx = '0;
        key_step = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      HELD: if (!key_s) begin
        state_nx = DB_REL;
        cnt_nx = '0;
      end
      DB_REL: if (key_s) begin
        state_nx = HELD;
        cnt_nx = '0;
      end else if (done) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else cnt_nx = cnt + 1'b1;
    endcase
  end
`ifdef STEP_FREE_RUN_EN
  logic run_s, div_tick;
  logic [DIV_W-1:0] div;
  sync_2ff u_run (.CLK(CLK), .RST(RST), .d(RUN_SW), .q(run_s));
  assign div_tick = run_s && div == DIV_W'(RUN_DIV - 1);
  always_ff @(posedge CLK)
    if (RST) div <= '0;
    else div <= (!run_s || div_tick) ? '0 : div + 1'b1;
  // key steps are masked while running, so a coincident key/div step collapses to one pulse
  assign step = div_tick || (key_step && !run_s);
`else
  logic [DIV_W:0] unused_cfg;
  assign unused_cfg = {RUN_SW, DIV_W'(RUN_DIV)};
  assign step = key_step;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      STEP_EN <= 1'b0;
      KEY_LEVEL <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      STEP_EN <= step;
      KEY_LEVEL <= state_nx == HELD || state_nx == DB_REL;
      STEP_CNT <= STEP_CNT + STEP_CNT_W'(STEP_EN);
    end
endmodule
